// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit_pkg
//  Purpose  : Shared encodings for the RV32M execute unit: funct3 op codes,
//             FSM state codes, multiplier select codes and the combinational
//             multiplier that the unit drives.
//  Revision : 1.0  initial release
// ============================================================================
package muldiv_unit_pkg;

   // funct3 encodings of the M extension
   typedef enum logic [2:0] {
      MD_OP_MUL    = 3'b000,
      MD_OP_MULH   = 3'b001,
      MD_OP_MULHSU = 3'b010,
      MD_OP_MULHU  = 3'b011,
      MD_OP_DIV    = 3'b100,
      MD_OP_DIVU   = 3'b101,
      MD_OP_REM    = 3'b110,
      MD_OP_REMU   = 3'b111
   } md_op_e;

   typedef enum logic [1:0] {
      MD_ST_IDLE = 2'd0,
      MD_ST_MUL  = 2'd1,
      MD_ST_DIV  = 2'd2,
      MD_ST_DONE = 2'd3
   } md_state_e;

   typedef enum logic [1:0] {
      MUL_LO    = 2'd0,
      MUL_HI    = 2'd1,
      MUL_HI_SU = 2'd2,
      MUL_HI_UU = 2'd3
   } mul_sel_e;

   // funct3[1:0] of a multiply op selects which product half / signedness
   function automatic mul_sel_e op_to_mul_sel(input logic [1:0] f);
      mul_sel_e s;
      case (f)
         2'b00:   s = MUL_LO;
         2'b01:   s = MUL_HI;
         2'b10:   s = MUL_HI_SU;
         default: s = MUL_HI_UU;
      endcase
      return s;
   endfunction

   // Combinational 32x32 multiplier: sign/zero-extend to 64 bits so the low
   // 64 bits of the product are correct for every signedness combination.
   function automatic logic [31:0] mul_compute(input mul_sel_e sel,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
      logic [63:0] ea;
      logic [63:0] eb;
      logic [63:0] p;
      ea = (sel == MUL_HI || sel == MUL_HI_SU) ? {{32{a[31]}}, a} : {32'b0, a};
      eb = (sel == MUL_HI) ? {{32{b[31]}}, b} : {32'b0, b};
      p  = ea * eb;
      return (sel == MUL_LO) ? p[31:0] : p[63:32];
   endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_divider_core.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit_divider_core
//  Purpose  : Unsigned restoring divider, one quotient bit per cycle.
//             o_quot/o_rem present the result of the step being taken in
//             the current cycle, so they are final while o_done is high.
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_unit_divider_core #(
   parameter int WIDTH = 32,
   parameter int ITERS = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic             i_kill,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quot,
   output logic [WIDTH-1:0] o_rem
);

   localparam int             CW     = $clog2(ITERS);
   localparam logic [CW-1:0]  C_LAST = CW'(ITERS - 1);

   logic             r_busy;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_div;

   logic [WIDTH:0]   w_part;
   logic [WIDTH:0]   w_trial;
   logic             w_fits;
   logic [WIDTH-1:0] w_rem_next;
   logic [WIDTH-1:0] w_quot_next;

   // 33-bit partial remainder: shift in next dividend bit, trial-subtract
   always_comb begin
      w_part      = {r_rem, r_quot[WIDTH-1]};
      w_trial     = w_part - {1'b0, r_div};
      w_fits      = ~w_trial[WIDTH];
      w_rem_next  = w_fits ? w_trial[WIDTH-1:0] : w_part[WIDTH-1:0];
      w_quot_next = {r_quot[WIDTH-2:0], w_fits};
   end

   // Load on start, then one restoring step per cycle until count hits zero
   always_ff @(posedge clk) begin
      if (reset || i_kill) begin
         r_busy  <= 1'b0;
         r_count <= '0;
         r_quot  <= '0;
         r_rem   <= '0;
         r_div   <= '0;
      end else if (i_start) begin
         r_busy  <= 1'b1;
         r_count <= C_LAST;
         r_quot  <= i_dividend;
         r_rem   <= '0;
         r_div   <= i_divisor;
      end else if (r_busy) begin
         r_quot  <= w_quot_next;
         r_rem   <= w_rem_next;
         if (r_count == '0) begin
            r_busy <= 1'b0;
         end else begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_busy && (r_count == '0);
   assign o_quot = w_quot_next;
   assign o_rem  = w_rem_next;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Multi-cycle RV32M execute unit. Multiplies in one cycle via the
//             combinational multiplier, divides on a 32-step restoring core,
//             handles divide-by-zero / overflow without iterating, and hands
//             results to writeback over a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int DIV_ITERS = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_op,
   input  logic [XLEN-1:0] req_op1,
   input  logic [XLEN-1:0] req_op2,
   input  logic            kill,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_data
);

   md_state_e       r_state;
   md_state_e       w_state_next;
   logic [XLEN-1:0] r_op1;
   logic [XLEN-1:0] r_op2;
   mul_sel_e        r_mul_sel;
   logic            r_neg_q;
   logic            r_neg_r;
   logic            r_is_rem;
   logic [XLEN-1:0] r_resp_data;

   logic            w_accept;
   logic            w_div_start;
   logic            w_signed_op;
   logic            w_div_zero;
   logic            w_ovf;
   logic            w_special;
   logic [XLEN-1:0] w_special_res;
   logic [XLEN-1:0] w_abs1;
   logic [XLEN-1:0] w_abs2;
   logic [XLEN-1:0] w_mul_result;
   logic [XLEN-1:0] w_div_fixed;
   logic            w_div_busy;
   logic            w_div_done;
   logic [XLEN-1:0] w_div_quot;
   logic [XLEN-1:0] w_div_rem;

   // Request decode: funct3[2] = divide class, [1] = remainder, [0] = unsigned
   always_comb begin
      w_signed_op = ~req_op[0];
      w_div_zero  = (req_op2 == '0);
      w_ovf       = w_signed_op && (req_op1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (req_op2 == '1);
      w_special   = w_div_zero || w_ovf;
      if (w_div_zero) begin
         w_special_res = req_op[1] ? req_op1 : '1;
      end else begin
         w_special_res = req_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      end
      w_abs1 = (w_signed_op && req_op1[XLEN-1]) ? -req_op1 : req_op1;
      w_abs2 = (w_signed_op && req_op2[XLEN-1]) ? -req_op2 : req_op2;
   end

   assign w_mul_result = mul_compute(r_mul_sel, r_op1, r_op2);

   // Sign fix-up of the unsigned divider result on its final step
   always_comb begin
      if (r_is_rem) begin
         w_div_fixed = r_neg_r ? -w_div_rem : w_div_rem;
      end else begin
         w_div_fixed = r_neg_q ? -w_div_quot : w_div_quot;
      end
   end

   muldiv_unit_divider_core #(
      .WIDTH (XLEN),
      .ITERS (DIV_ITERS)
   ) u_div (
      .clk        (clk),
      .reset      (reset),
      .i_start    (w_div_start),
      .i_kill     (kill),
      .i_dividend (w_abs1),
      .i_divisor  (w_abs2),
      .o_busy     (w_div_busy),
      .o_done     (w_div_done),
      .o_quot     (w_div_quot),
      .o_rem      (w_div_rem)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= MD_ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; kill overrides everything, including a pending accept
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_div_start  = 1'b0;
      case (r_state)
         MD_ST_IDLE: begin
            if (req_valid) begin
               w_accept = 1'b1;
               if (!req_op[2]) begin
                  w_state_next = MD_ST_MUL;
               end else if (w_special) begin
                  w_state_next = MD_ST_DONE;
               end else begin
                  w_state_next = MD_ST_DIV;
                  w_div_start  = 1'b1;
               end
            end
         end
         MD_ST_MUL:  w_state_next = MD_ST_DONE;
         MD_ST_DIV: begin
            if (w_div_busy && w_div_done) begin
               w_state_next = MD_ST_DONE;
            end
         end
         MD_ST_DONE: begin
            if (resp_ready) begin
               w_state_next = MD_ST_IDLE;
            end
         end
         default:    w_state_next = MD_ST_IDLE;
      endcase
      if (kill) begin
         w_state_next = MD_ST_IDLE;
         w_accept     = 1'b0;
         w_div_start  = 1'b0;
      end
   end

   // Operand latches and result register; result only written outside DONE
   always_ff @(posedge clk) begin
      if (reset) begin
         r_op1       <= '0;
         r_op2       <= '0;
         r_mul_sel   <= MUL_LO;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_is_rem    <= 1'b0;
         r_resp_data <= '0;
      end else begin
         if (w_accept) begin
            r_op1     <= req_op1;
            r_op2     <= req_op2;
            r_mul_sel <= op_to_mul_sel(req_op[1:0]);
            r_neg_q   <= w_signed_op && (req_op1[XLEN-1] ^ req_op2[XLEN-1]);
            r_neg_r   <= w_signed_op && req_op1[XLEN-1];
            r_is_rem  <= req_op[1];
            if (req_op[2] && w_special) begin
               r_resp_data <= w_special_res;
            end
         end
         if (!kill && r_state == MD_ST_MUL) begin
            r_resp_data <= w_mul_result;
         end
         if (!kill && r_state == MD_ST_DIV && w_div_done) begin
            r_resp_data <= w_div_fixed;
         end
      end
   end

   assign req_ready  = (r_state == MD_ST_IDLE);
   assign resp_valid = (r_state == MD_ST_DONE);
   assign resp_data  = r_resp_data;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_unit
//  Purpose  : Directed self-checking bench for muldiv_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_op1;
   logic [31:0] req_op2;
   logic        kill;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;

   int n_vec;
   int n_err;

   muldiv_unit #(
      .XLEN      (32),
      .DIV_ITERS (32)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_op1    (req_op1),
      .req_op2    (req_op2),
      .kill       (kill),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present a request at a negedge; accept edge is the following posedge
   task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      req_valid = 1'b1;
      req_op    = op;
      req_op1   = a;
      req_op2   = b;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Called at the negedge of cycle 1; measures cycles until resp_valid
   task automatic wait_resp(input string tag, input logic [31:0] exp, input int exp_lat);
      int lat;
      lat = 1;
      while (resp_valid !== 1'b1 && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check(tag, resp_data, exp);
   endtask

   task automatic consume();
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      send(op, a, b);
      wait_resp(tag, exp, exp_lat);
      consume();
   endtask

   // Watch for a number of cycles and report whether resp_valid ever rose
   task automatic never_valid(input string tag, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         seen = seen | resp_valid;
      end
      check(tag, {31'b0, seen}, 32'd0);
   endtask

   initial begin
      n_vec      = 0;
      n_err      = 0;
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_op     = 3'b000;
      req_op1    = '0;
      req_op2    = '0;
      kill       = 1'b0;
      resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset req_ready", {31'b0, req_ready}, 32'd1);
      check("reset resp_valid", {31'b0, resp_valid}, 32'd0);
      check("reset resp_data", resp_data, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Multiplies
      run("MULH min*min",  3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
      run("MUL 7*-3",      3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
      run("MULHU max*max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
      run("MULHSU -1*max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);

      // Normal divides
      run("DIV -7/2",      3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
      run("REM -7/2",      3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
      run("DIVU 100/7",    3'b101, 32'd100,       32'd7, 32'd14,        33);
      run("REMU 100/7",    3'b111, 32'd100,       32'd7, 32'd2,         33);
      run("DIV 7/-2",      3'b100, 32'd7,  32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
      run("REM 7/-2",      3'b110, 32'd7,  32'hFFFF_FFFE, 32'd1,         33);
      run("DIVU max/1",    3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);

      // Special cases
      run("DIVU 5/0",      3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      run("REMU 5/0",      3'b111, 32'd5, 32'd0, 32'd5,         1);
      run("REM -5/0",      3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);
      run("DIV ovf",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run("REM ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

      // Writeback stall: result held, no new request accepted meanwhile
      send(3'b101, 32'd100, 32'd7);
      wait_resp("stall DIVU", 32'd14, 33);
      req_valid = 1'b1;
      req_op    = 3'b000;
      req_op1   = 32'd3;
      req_op2   = 32'd4;
      for (int i = 0; i < 10; i++) begin
         check("stall resp_valid", {31'b0, resp_valid}, 32'd1);
         check("stall resp_data", resp_data, 32'd14);
         check("stall req_ready", {31'b0, req_ready}, 32'd0);
         @(negedge clk);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check("release req_ready", {31'b0, req_ready}, 32'd1);
      check("release resp_valid", {31'b0, resp_valid}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      wait_resp("MUL after stall", 32'd12, 2);
      consume();

      // Kill at cycle 10 of a divide
      send(3'b101, 32'd100, 32'd7);
      repeat (9) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      check("kill req_ready", {31'b0, req_ready}, 32'd1);
      check("kill resp_valid", {31'b0, resp_valid}, 32'd0);
      never_valid("kill no resp", 40);
      run("MUL 3*4 after kill", 3'b000, 32'd3, 32'd4, 32'd12, 2);

      // Reset at cycle 5 of a divide
      send(3'b100, 32'hFFFF_FFF9, 32'd2);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst req_ready", {31'b0, req_ready}, 32'd1);
      check("rst resp_data", resp_data, 32'd0);
      never_valid("rst no resp", 40);
      run("MUL 3*4 after rst", 3'b000, 32'd3, 32'd4, 32'd12, 2);

      // kill beats req_valid in IDLE
      req_valid = 1'b1;
      req_op    = 3'b000;
      req_op1   = 32'd5;
      req_op2   = 32'd5;
      kill      = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      kill      = 1'b0;
      never_valid("kill vs req", 4);

      // kill in DONE drops the result
      send(3'b101, 32'd5, 32'd0);
      check("done before kill", {31'b0, resp_valid}, 32'd1);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      check("done kill resp_valid", {31'b0, resp_valid}, 32'd0);
      check("done kill req_ready", {31'b0, req_ready}, 32'd1);
      run("MULHU after done kill", 3'b011, 32'h0001_0000, 32'h0001_0000, 32'd1, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle RV32M execute unit sitting between the decode/issue stage and writeback. It accepts one M-extension operation per request and drives the existing combinational multiplier: operands, plus `mul_sel` derived from funct3. It registers that multiplier's 32-bit result. DIV/DIVU/REM/REMU run on an internal 32-iteration restoring divider. A valid/ready handshake on both sides lets the core stall issue and writeback.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
DIV_ITERS, 32, divider iterations; must equal XLEN

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept request this cycle
req_op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
req_op1  input  32  rs1 value
req_op2  input  32  rs2 value
kill  input  1  pipeline flush; abort current op
resp_valid  output  1  result available
resp_ready  input  1  writeback accepts result
resp_data  output  32  result

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_data=0, all operand/divider registers=0.
- States and transitions:
  - IDLE: req_ready=1. A request is accepted when req_valid&&req_ready&&!kill.
    - MUL-class op: latch op1, op2, mul_sel, go to MUL.
    - DIV-class op with op2==0 or signed overflow (op1=0x80000000, op2=0xFFFFFFFF, DIV/REM only): write special result to resp_data, go to DONE.
    - Otherwise: load divider, go to DIV.
  - MUL: multiplier inputs come from the latched registers. Capture multiplier_result into resp_data; go to DONE.
  - DIV: one restoring step per cycle; counter counts DIV_ITERS-1 down to 0. After the last step, sign-fix and write resp_data; go to DONE.
  - DONE: resp_valid=1, resp_data held stable. On resp_ready, go to IDLE.
- req_ready is 1 only in IDLE; no request is accepted while DONE is stalled.
- Latency (accept edge = cycle 0):
  - MUL ops: resp_valid from cycle 2.
  - Special-case divides: resp_valid from cycle 1.
  - Normal divides: DIV occupies cycles 1..32; resp_valid from cycle 33.
  - Back-to-back issue is possible the cycle after a response is consumed.
- mul_sel mapping: 000→MUL_LO, 001→MUL_HI, 010→MUL_HI_SU, 011→MUL_HI_UU (codes from consts.vh).
- Divide arithmetic:
  - Signed ops use |op1| and |op2| as unsigned operands.
  - Quotient is negated if signs differ (DIV).
  - Remainder takes the sign of the dividend (REM).
  - Unsigned ops are used as-is.
  - Partial remainder is 33 bits to hold the trial subtract.
- Special results:
  - Divide by zero: DIV/DIVU→0xFFFFFFFF; REM/REMU→op1.
  - Overflow: DIV→0x80000000; REM→0.
- kill (any state but DONE): next state IDLE, resp_valid stays 0, divider contents discarded.
  - kill in DONE: drop the result, go to IDLE.
  - kill has priority over req_valid and resp_ready in the same cycle.
- reset mid-operation: identical to kill plus register clear.
- resp_data must not change while resp_valid=1 and resp_ready=0.

Decomposition:
- consts.vh gains:
  - MD_OP_* funct3 defines (8 codes).
  - MD_ST_IDLE/MUL/DIV/DONE state encodings (2 bits).
- MUL_LO/MUL_HI/MUL_HI_SU/MUL_HI_UU are reused from there.
- One natural sub-module: divider_core.
  - Holds the restoring iteration: remainder, quotient and count registers.
  - Signals: start/busy/done; outputs unsigned quotient and remainder.
- muldiv_unit holds the FSM, special-case detection, sign fix-up and the multiplier instance.

Test Plan:
- MULH op1=0x80000000, op2=0x80000000 → resp_data=0x40000000, resp_valid 2 cycles after accept; MUL 7×(-3) → 0xFFFFFFEB.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU op1=0xFFFFFFFF, op2=0xFFFFFFFF → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD and REM -7/2 → 0xFFFFFFFF, each with resp_valid 33 cycles after accept; DIVU 100/7 → 14, REMU → 2.
- DIVU 5/0 → 0xFFFFFFFF, REMU 5/0 → 5, DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0; all with 1-cycle latency.
- Hold resp_ready=0 for 10 cycles after a DIV completes → resp_valid and resp_data stable, req_ready=0; release → IDLE next cycle, new MUL accepted.
- Assert kill at cycle 10 of a DIV (and separately reset at cycle 5) → no resp_valid ever, req_ready=1 next cycle; following MUL 3×4 returns 12.
